uart_tx_ctrl: RTL

- Transmit-side sequencer for the team's UART. It accepts one byte over a valid/ready handshake and serialises it onto serial_out as a start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits.
- Owns bit timing (baud counter), the bit counter and the shift register.
- Mirrors the receiver control unit; both sides share the same CLKS_PER_BIT timing.

---
 rtl/uart_tx_ctrl_if.sv | 11 +
 rtl/uart_tx_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a producer and the UART transmit sequencer.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte on a valid/ready handshake and
// serialises start bit, LSB-first data bits and stop bits onto serial_out.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               n_rst,
  uart_tx_ctrl_if.slave      bus,
  output logic               serial_out,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [BW-1:0]        baud;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 baud_wrap;

  assign baud_wrap = (baud == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_valid) begin
            shreg   <= bus.tx_data;
            baud    <= '0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud  <= '0;
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud  <= '0;
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            if (bit_cnt == CW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud <= '0;
            if (bit_cnt == CW'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line and status are decoded purely from registered state.
  always_comb begin
    serial_out = 1'b1;
    case (state)
      START:   serial_out = 1'b0;
      DATA:    serial_out = shreg[0];
      default: serial_out = 1'b1;
    endcase
  end

  assign tx_busy      = (state != IDLE);
  assign bus.tx_ready = (state == IDLE);

endmodule
